// File: rtl/reg_scoreboard_if.sv
// Decode/writeback/scoreboard bundle between the issue stage, the regfile write port and reg_scoreboard.
// master = pipeline side (drives issue, writeback, flush); slave = scoreboard side.
// Carries the ready handshake and the registered status outputs.
interface reg_scoreboard_if;
  logic        issue_valid;
  logic        issue_ready;
  logic [4:0]  issue_rs1;
  logic        issue_rs1_used;
  logic [4:0]  issue_rs2;
  logic        issue_rs2_used;
  logic [4:0]  issue_rd;
  logic        issue_rd_wr;
  logic        wb_en;
  logic [4:0]  wb_reg;
  logic        flush;
  logic [31:0] busy;
  logic [31:0] stall_cnt;
  logic        wb_underflow;

  modport master (
    output issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
           issue_rd, issue_rd_wr, wb_en, wb_reg, flush,
    input  issue_ready, busy, stall_cnt, wb_underflow
  );

  modport slave (
    input  issue_valid, issue_rs1, issue_rs1_used, issue_rs2, issue_rs2_used,
           issue_rd, issue_rd_wr, wb_en, wb_reg, flush,
    output issue_ready, busy, stall_cnt, wb_underflow
  );
endinterface

// File: rtl/reg_scoreboard.sv
// RAW scoreboard for x1..x31: per-register pending-write counters gate decode issue.
// issue_ready is combinational (zero latency); busy/stall_cnt/wb_underflow are registered, one-cycle update.
// Backpressure: issue_ready drops on source hazard, counter saturation or flush.
// Optional feature macro SCOREBOARD_WB_BYPASS_EN: a source whose last pending write is on the
// regfile write port this cycle does not stall (needs regfile write-through/forwarding).
module reg_scoreboard #(
  parameter int CNT_WIDTH = 2
) (
  input  logic            clk,
  input  logic            rst,
  reg_scoreboard_if.slave sb
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;

  // Per-register in-flight write counts; entry 0 is held at zero so x0 never looks busy.
  logic [CNT_WIDTH-1:0] r_pending [0:31];
  logic [31:0]          r_stall_cnt;
  logic                 r_wb_underflow;

  logic [CNT_WIDTH-1:0] w_rs1_pend;
  logic [CNT_WIDTH-1:0] w_rs2_pend;
  logic [CNT_WIDTH-1:0] w_rd_pend;
  logic [CNT_WIDTH-1:0] w_wb_pend;
  logic                 w_rs1_haz;
  logic                 w_rs2_haz;
  logic                 w_sat_haz;
  logic                 w_ready;
  logic                 w_fire_wr;
  logic                 w_wb_live;
  logic                 w_underflow_nxt;
  logic [31:0]          w_busy;

  assign w_rs1_pend = r_pending[sb.issue_rs1];
  assign w_rs2_pend = r_pending[sb.issue_rs2];
  assign w_rd_pend  = r_pending[sb.issue_rd];
  assign w_wb_pend  = r_pending[sb.wb_reg];

  // A writeback to x0 is dropped by the regfile, so it is ignored here too.
  assign w_wb_live = sb.wb_en && (sb.wb_reg != 5'd0);

  // Source hazard detection; the bypass lets a source through when its only pending write lands now.
  always_comb begin
    w_rs1_haz = sb.issue_rs1_used && (sb.issue_rs1 != 5'd0) && (w_rs1_pend != CNT_ZERO);
    w_rs2_haz = sb.issue_rs2_used && (sb.issue_rs2 != 5'd0) && (w_rs2_pend != CNT_ZERO);
`ifdef SCOREBOARD_WB_BYPASS_EN
    if (w_rs1_pend == CNT_ONE && w_wb_live && sb.wb_reg == sb.issue_rs1) begin
      w_rs1_haz = 1'b0;
    end
    if (w_rs2_pend == CNT_ONE && w_wb_live && sb.wb_reg == sb.issue_rs2) begin
      w_rs2_haz = 1'b0;
    end
`endif
  end

  // A saturated counter cannot track another write, so the issue must wait for a writeback.
  assign w_sat_haz = sb.issue_rd_wr && (sb.issue_rd != 5'd0) && (w_rd_pend == CNT_MAX);

  // Ready deliberately ignores issue_valid so decode can look at it before committing.
  assign w_ready     = !(w_rs1_haz || w_rs2_haz || w_sat_haz) && !sb.flush;
  assign w_fire_wr   = sb.issue_valid && w_ready && sb.issue_rd_wr;
  assign w_underflow_nxt = w_wb_live && (w_wb_pend == CNT_ZERO) && !sb.flush;

  // Pending counters: reset/flush clear everything, otherwise each register nets its inc and dec.
  always_ff @(posedge clk) begin
    if (rst || sb.flush) begin
      for (int r = 0; r < 32; r++) begin
        r_pending[r] <= CNT_ZERO;
      end
    end else begin
      for (int r = 1; r < 32; r++) begin
        logic v_inc;
        logic v_dec;
        v_inc = w_fire_wr && (sb.issue_rd == 5'(r));
        v_dec = w_wb_live && (sb.wb_reg == 5'(r)) && (r_pending[r] != CNT_ZERO);
        case ({v_inc, v_dec})
          2'b10:   r_pending[r] <= r_pending[r] + CNT_ONE;
          2'b01:   r_pending[r] <= r_pending[r] - CNT_ONE;
          default: r_pending[r] <= r_pending[r];
        endcase
      end
    end
  end

  // Saturating stall counter; flush cycles with a presented instruction count as stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cnt <= 32'd0;
    end else if (sb.issue_valid && !w_ready && (r_stall_cnt != 32'hFFFF_FFFF)) begin
      r_stall_cnt <= r_stall_cnt + 32'd1;
    end
  end

  // One-cycle pulse when a writeback arrives for a register with nothing in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_underflow <= 1'b0;
    end else begin
      r_wb_underflow <= w_underflow_nxt;
    end
  end

  // Busy view derived from the registered counters.
  always_comb begin
    w_busy = 32'd0;
    for (int r = 1; r < 32; r++) begin
      w_busy[r] = (r_pending[r] != CNT_ZERO);
    end
  end

  assign sb.issue_ready  = w_ready;
  assign sb.busy         = w_busy;
  assign sb.stall_cnt    = r_stall_cnt;
  assign sb.wb_underflow = r_wb_underflow;

endmodule

// File: tb/tb_reg_scoreboard.sv
// Directed self-checking bench for reg_scoreboard (CNT_WIDTH = 2).
// Inputs change 1 time unit after posedge; outputs are checked mid-cycle.
// Expected values are hand-derived; bypass-dependent values follow SCOREBOARD_WB_BYPASS_EN.
module tb_reg_scoreboard;
  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   exp_stall;

  reg_scoreboard_if sb ();

  reg_scoreboard #(.CNT_WIDTH(2)) dut (
    .clk (clk),
    .rst (rst),
    .sb  (sb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    sb.issue_valid    = 1'b0;
    sb.issue_rs1      = 5'd0;
    sb.issue_rs1_used = 1'b0;
    sb.issue_rs2      = 5'd0;
    sb.issue_rs2_used = 1'b0;
    sb.issue_rd       = 5'd0;
    sb.issue_rd_wr    = 1'b0;
    sb.wb_en          = 1'b0;
    sb.wb_reg         = 5'd0;
    sb.flush          = 1'b0;
  endtask

  task automatic issue_wr(input logic [4:0] rd);
    idle();
    sb.issue_valid = 1'b1;
    sb.issue_rd    = rd;
    sb.issue_rd_wr = 1'b1;
  endtask

  task automatic wb(input logic [4:0] r);
    idle();
    sb.wb_en  = 1'b1;
    sb.wb_reg = r;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_stall = 0;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    chk("reset_busy", sb.busy, 32'h0);
    chk("reset_stall", sb.stall_cnt, 32'd0);
    chk("reset_uflow", {31'd0, sb.wb_underflow}, 32'd0);
    chk("reset_ready", {31'd0, sb.issue_ready}, 32'd1);

    // RAW on x5
    issue_wr(5'd5);
    #1 chk("rd5_ready", {31'd0, sb.issue_ready}, 32'd1);
    tick();
    idle();
    chk("rd5_busy", sb.busy, 32'h0000_0020);
    sb.issue_valid = 1'b1;
    sb.issue_rs1 = 5'd5;
    sb.issue_rs1_used = 1'b1;
    #1 chk("raw_stall_ready", {31'd0, sb.issue_ready}, 32'd0);
    tick();
    chk("raw_stall_cnt1", sb.stall_cnt, 32'd1);
    tick();
    chk("raw_stall_cnt2", sb.stall_cnt, 32'd2);
    sb.wb_en = 1'b1;
    sb.wb_reg = 5'd5;
    #1;
`ifdef SCOREBOARD_WB_BYPASS_EN
    chk("wb_same_cycle_ready", {31'd0, sb.issue_ready}, 32'd1);
    exp_stall = 2;
`else
    chk("wb_same_cycle_ready", {31'd0, sb.issue_ready}, 32'd0);
    exp_stall = 3;
`endif
    tick();
    sb.wb_en = 1'b0;
    sb.wb_reg = 5'd0;
    #1 chk("wb_next_ready", {31'd0, sb.issue_ready}, 32'd1);
    chk("wb_stall_cnt", sb.stall_cnt, 32'(exp_stall));
    chk("wb_busy_clear", sb.busy, 32'h0);
    tick();
    chk("raw_issue_no_stall", sb.stall_cnt, 32'(exp_stall));

    // x0 is never tracked
    idle();
    sb.issue_valid = 1'b1;
    sb.issue_rd_wr = 1'b1;
    sb.issue_rs1_used = 1'b1;
    sb.issue_rs2_used = 1'b1;
    #1 chk("x0_ready", {31'd0, sb.issue_ready}, 32'd1);
    tick();
    chk("x0_busy", sb.busy, 32'h0);
    wb(5'd0);
    tick();
    idle();
    #1 chk("x0_wb_no_uflow", {31'd0, sb.wb_underflow}, 32'd0);

    // Saturation on x7
    issue_wr(5'd7);
    tick();
    tick();
    tick();
    chk("sat_busy", sb.busy, 32'h0000_0080);
    chk("sat_ready", {31'd0, sb.issue_ready}, 32'd0);
    sb.wb_en = 1'b1;
    sb.wb_reg = 5'd7;
    #1 chk("sat_wb_same_ready", {31'd0, sb.issue_ready}, 32'd0);
    tick();
    exp_stall++;
    sb.wb_en = 1'b0;
    sb.wb_reg = 5'd0;
    #1 chk("sat_wb_next_ready", {31'd0, sb.issue_ready}, 32'd1);
    chk("sat_stall_cnt", sb.stall_cnt, 32'(exp_stall));
    tick();
    idle();
    #1 chk("sat_refill_ready", {31'd0, sb.issue_ready}, 32'd1);

    // Same-cycle issue and writeback to x9 with pending 1
    issue_wr(5'd9);
    tick();
    sb.wb_en = 1'b1;
    sb.wb_reg = 5'd9;
    tick();
    idle();
    #1 chk("inc_dec_busy", sb.busy, 32'h0000_0280);
    chk("inc_dec_no_uflow", {31'd0, sb.wb_underflow}, 32'd0);
    wb(5'd9);
    tick();
    idle();
    #1 chk("x9_single_drain", sb.busy, 32'h0000_0080);
    chk("x9_drain_no_uflow", {31'd0, sb.wb_underflow}, 32'd0);

    // Underflow on x12
    wb(5'd12);
    tick();
    idle();
    #1 chk("uflow_pulse", {31'd0, sb.wb_underflow}, 32'd1);
    chk("uflow_busy", sb.busy, 32'h0000_0080);
    tick();
    chk("uflow_one_cycle", {31'd0, sb.wb_underflow}, 32'd0);

    // Drain x7, then build busy = 0x460 and flush
    wb(5'd7);
    tick();
    tick();
    tick();
    idle();
    #1 chk("x7_drained", sb.busy, 32'h0);
    issue_wr(5'd5);
    tick();
    issue_wr(5'd6);
    tick();
    issue_wr(5'd10);
    tick();
    idle();
    #1 chk("pre_flush_busy", sb.busy, 32'h0000_0460);
    issue_wr(5'd11);
    sb.flush = 1'b1;
    sb.wb_en = 1'b1;
    sb.wb_reg = 5'd13;
    #1 chk("flush_ready", {31'd0, sb.issue_ready}, 32'd0);
    tick();
    exp_stall++;
    idle();
    #1 chk("flush_busy", sb.busy, 32'h0);
    chk("flush_no_uflow", {31'd0, sb.wb_underflow}, 32'd0);
    chk("flush_stall_cnt", sb.stall_cnt, 32'(exp_stall));

    // Reset mid-sequence
    issue_wr(5'd3);
    tick();
    idle();
    #1 chk("pre_rst_busy", sb.busy, 32'h0000_0008);
    issue_wr(5'd4);
    sb.wb_en = 1'b1;
    sb.wb_reg = 5'd12;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    #1 chk("rst_busy", sb.busy, 32'h0);
    chk("rst_stall", sb.stall_cnt, 32'd0);
    chk("rst_uflow", {31'd0, sb.wb_underflow}, 32'd0);
    wb(5'd3);
    tick();
    idle();
    #1 chk("post_rst_uflow", {31'd0, sb.wb_underflow}, 32'd1);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
